wave_gen: RTL and testbench
===========================

# wave_gen

Sample-rate waveform synthesiser that produces the 8-bit unsigned amplitude consumed by the PWM audio output stage. A phase accumulator advances once per sample period and is shaped into square, sawtooth, triangle or sine, then scaled by a runtime amplitude. The result is offset-binary: 0x80 is silence. The sample period is fixed at SAMPLE_DIV clocks, so one sample spans exactly one PWM ramp when SAMPLE_DIV = 256.

## Interface
- SAMPLE_DIV, 256: clocks per sample; must be at least 4.
- PHASE_W, 24: phase accumulator width; must be at least 8.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run the generator; 0 holds phase at 0 and forces silence.
- freq_word  in  PHASE_W  phase increment per sample; f_out = freq_word·(f_clk/SAMPLE_DIV)/2^PHASE_W.
- wave_sel  in  2  waveform select: 0 square, 1 saw, 2 triangle, 3 sine.
- amplitude  in  8  unsigned gain: 0 is mute, 255 is approximately full scale.
- value  out  8  offset-binary sample to the PWM stage.
- value_valid  out  1  one-cycle pulse when value updates.
- sample_tick  out  1  one-cycle pulse that marks the start of each sample period.

## Operation
- **Divider:** counter runs 0..SAMPLE_DIV-1 and wraps. sample_tick = (counter == SAMPLE_DIV-1).
- **Tick edge (the clock edge ending a tick cycle):**
  - phase ← enable ? phase + freq_word (mod 2^PHASE_W) : 0.
  - wave_sel, amplitude and enable are captured into shadow registers.
  - Inputs are ignored between ticks, so changes take effect glitch-free.
- **Shaping:** p = phase[PHASE_W-1 -: 8]; the result s is signed 8-bit.
  - Square: s = p[7] ? -127 : +127.
  - Saw: s = p XOR 0x80, read as signed (range -128..127).
  - Triangle: u = p[7] ? 127 - p[6:0] : p[6:0]; s = 2u - 127 (range -127..127).
  - Sine: addr = p[6] ? 63 - p[5:0] : p[5:0]; m = rom[addr]; s = p[7] ? -m : m.
  - rom[a] = round(127·sin((a+0.5)·π/128)), so rom[0] = 2 and rom[63] = 127.
- **Scaling:** prod = s × {0, amplitude}, computed as 17-bit signed. scaled = prod >>> 8, an arithmetic (floor) shift.
- **Output:** value = scaled + 128, i.e. scaled with bit 7 inverted. No saturation is needed: the range is 0..254.
- **Enable low:** the captured enable forces scaled = 0, so value = 0x80 at the next update.
- **Wrap-around:** phase overflow wraps silently. freq_word = 2^PHASE_W - k behaves as a negative step of k.

## Timing
- Reset values: counter 0, phase 0, all shaping and scaling stages 0, value 0x80, value_valid 0, sample_tick 0, shadow registers 0.
- First sample_tick occurs in cycle SAMPLE_DIV-1 after rst is released.
- Pipeline, with the tick in cycle T:
  - Edge ending T: phase is updated.
  - Edge ending T+1: s is registered.
  - Edge ending T+2: value is registered.
  - value_valid is high during cycle T+3 only.
- Fixed latency: value reflects the phase updated at tick T, 3 edges after the tick is sampled.
- value holds steady between updates.
- rst asserted mid-sample: every register returns to its reset value on the next edge, and in-flight pipeline stages are discarded.
- freq_word may change at any time; only its value at the tick edge is used.

## Structure
- Shared package wave_pkg holds:
  - the wave_sel encodings (WAVE_SQUARE, WAVE_SAW, WAVE_TRI, WAVE_SINE);
  - the SILENCE = 8'h80 constant;
  - the signed sample typedef.
- Sub-module sine_quarter_rom: 64×8 synchronous-read quarter-wave table.
  - Registered output aligns with the shaping stage.
  - Sign and mirroring logic stays in wave_gen.

## Test plan
Unless a scenario states otherwise, PHASE_W = 24, SAMPLE_DIV = 256 and amplitude = 255.
- **Reset:** hold rst for 5 cycles, then release.
  - value = 0x80 and value_valid = 0 until the first update.
  - First sample_tick appears at cycle 255.
- **Square:** freq_word = 0x010000 (p advances 1 per sample), enable = 1.
  - value = 254 for 128 consecutive samples, then 1 for 128.
  - value_valid pulses exactly 3 cycles after each tick.
- **Saw:** same freq_word as the square scenario, on the sample where p = 0x00, and on the sample where p = 0xFF.
  - p = 0x00 gives value = 0.
  - p = 0xFF gives value = 254.
  - With amplitude = 0, every sample gives value = 128.
- **Sine:** p = 0x40 gives value = 254; p = 0xC0 gives value = 1; p = 0x00 gives value = 129.
- **Wrap and reverse:** freq_word = 0xFF0000 with saw selected.
  - p decrements by 1 per sample and wraps 0x00 → 0xFF.
  - value steps from 0 to 254 at the wrap.
- **Enable and mid-run events:**
  - Drop enable mid-period: value = 128 after the next tick plus 3 cycles, and phase reads 0.
  - Change wave_sel between ticks: no value change until the next tick.
  - Assert rst mid-pipeline: the next edge gives value = 0x80 and value_valid = 0.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared types and constants for the sample-rate waveform synthesiser.
package wave_pkg;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SINE   = 2'd3
    } wave_sel_e;

    localparam logic [7:0] SILENCE = 8'h80;

    typedef logic signed [7:0] sample_t;

endpackage

// File: rtl/wave_gen_if.sv
// Control and sample-output bundle between the synthesiser and its consumer.
interface wave_gen_if #(
    parameter int unsigned PHASE_W = 24
);
    import wave_pkg::*;

    logic               enable;
    logic [PHASE_W-1:0] freq_word;
    wave_sel_e          wave_sel;
    logic [7:0]         amplitude;
    logic [7:0]         value;
    logic               value_valid;
    logic               sample_tick;

    modport master (
        output enable, freq_word, wave_sel, amplitude,
        input  value, value_valid, sample_tick
    );

    modport slave (
        input  enable, freq_word, wave_sel, amplitude,
        output value, value_valid, sample_tick
    );

endinterface

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine table, rom[a] = round(127*sin((a+0.5)*pi/128)), with registered read.
module sine_quarter_rom (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] addr_i,
    output logic [7:0] data_o
);

    localparam logic [7:0] Table [64] = '{
        8'd2,   8'd5,   8'd8,   8'd11,  8'd14,  8'd17,  8'd20,  8'd23,
        8'd26,  8'd29,  8'd32,  8'd35,  8'd38,  8'd41,  8'd44,  8'd47,
        8'd50,  8'd53,  8'd56,  8'd58,  8'd61,  8'd64,  8'd67,  8'd69,
        8'd72,  8'd74,  8'd77,  8'd79,  8'd82,  8'd84,  8'd86,  8'd89,
        8'd91,  8'd93,  8'd95,  8'd97,  8'd99,  8'd101, 8'd103, 8'd105,
        8'd106, 8'd108, 8'd110, 8'd111, 8'd113, 8'd114, 8'd115, 8'd117,
        8'd118, 8'd119, 8'd120, 8'd121, 8'd122, 8'd123, 8'd124, 8'd124,
        8'd125, 8'd125, 8'd126, 8'd126, 8'd127, 8'd127, 8'd127, 8'd127
    };

    logic [7:0] data_q, data_d;

    always_comb begin
        data_d = Table[addr_i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/wave_gen.sv
// Phase-accumulator waveform synthesiser: square/saw/triangle/sine, scaled, offset-binary out.
module wave_gen
    import wave_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 256,
    parameter int unsigned PHASE_W    = 24
) (
    input logic       clk,
    input logic       rst,
    wave_gen_if.slave bus_io
);

    localparam int unsigned     CntW    = $clog2(SAMPLE_DIV);
    localparam logic [CntW-1:0] CntLast = CntW'(SAMPLE_DIV - 1);

    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               tick;
    logic [PHASE_W-1:0] phase_q, phase_d;
    wave_sel_e          sel_q, sel_d;
    logic [7:0]         amp_q, amp_d;
    logic               en_q, en_d;
    logic               tick1_q, tick2_q, valid_q;
    sample_t            shape_q, shape_d;
    logic               is_sine_q, sine_neg_q;
    logic [7:0]         p;
    logic [5:0]         rom_addr;
    logic [7:0]         rom_data;
    sample_t            s;
    sample_t            scaled;
    logic signed [16:0] s_ext, amp_ext, prod;
    logic [7:0]         value_q, value_d;

    assign tick = (cnt_q == CntLast);

    // Inputs are sampled only on the tick edge so mid-period changes never glitch the output.
    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        phase_d = phase_q;
        sel_d   = sel_q;
        amp_d   = amp_q;
        en_d    = en_q;
        if (tick) begin
            phase_d = bus_io.enable ? phase_q + bus_io.freq_word : '0;
            sel_d   = bus_io.wave_sel;
            amp_d   = bus_io.amplitude;
            en_d    = bus_io.enable;
        end
    end

    always_comb begin
        p        = phase_q[PHASE_W-1 -: 8];
        rom_addr = p[6] ? ~p[5:0] : p[5:0];
        shape_d  = '0;
        unique case (sel_q)
            WAVE_SQUARE: shape_d = p[7] ? -8'sd127 : 8'sd127;
            WAVE_SAW:    shape_d = sample_t'(p ^ 8'h80);
            // 2u - 127 == (2u + 1) with the MSB flipped
            WAVE_TRI:    shape_d = p[7] ? {p[6], ~p[5:0], 1'b1} : {~p[6], p[5:0], 1'b1};
            WAVE_SINE:   shape_d = '0;
        endcase
    end

    sine_quarter_rom u_rom (
        .clk    (clk),
        .rst    (rst),
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    always_comb begin
        if (is_sine_q) begin
            s = sine_neg_q ? sample_t'(8'd0 - rom_data) : sample_t'(rom_data);
        end else begin
            s = shape_q;
        end
        s_ext   = {{9{s[7]}}, s};
        amp_ext = {9'd0, amp_q};
        prod    = s_ext * amp_ext;
        scaled  = sample_t'(prod >>> 8);
        value_d = en_q ? {~scaled[7], scaled[6:0]} : SILENCE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            phase_q    <= '0;
            sel_q      <= WAVE_SQUARE;
            amp_q      <= '0;
            en_q       <= 1'b0;
            tick1_q    <= 1'b0;
            tick2_q    <= 1'b0;
            valid_q    <= 1'b0;
            shape_q    <= '0;
            is_sine_q  <= 1'b0;
            sine_neg_q <= 1'b0;
            value_q    <= SILENCE;
        end else begin
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            sel_q      <= sel_d;
            amp_q      <= amp_d;
            en_q       <= en_d;
            tick1_q    <= tick;
            tick2_q    <= tick1_q;
            valid_q    <= tick2_q;
            shape_q    <= shape_d;
            is_sine_q  <= (sel_q == WAVE_SINE);
            sine_neg_q <= p[7];
            if (tick2_q) begin
                value_q <= value_d;
            end
        end
    end

    assign bus_io.sample_tick = tick;
    assign bus_io.value       = value_q;
    assign bus_io.value_valid = valid_q;

endmodule

// File: tb/tb_wave_gen.sv
// Self-checking bench for wave_gen: directed scenarios plus random samples vs. an arithmetic model.
module tb_wave_gen;
    import wave_pkg::*;

    localparam int unsigned SampleDiv = 256;
    localparam int unsigned PhaseW    = 24;
    localparam real         Pi        = 3.14159265358979;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wave_gen_if #(.PHASE_W(PhaseW)) bus_if ();

    wave_gen #(
        .SAMPLE_DIV (SampleDiv),
        .PHASE_W    (PhaseW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus_if)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned phase_m     = 0;
    int          last_exp    = 128;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Expected output from the shaping/scaling rules using plain integer and real arithmetic.
    function automatic int model_value(int unsigned ph, int sel, int amp, bit en);
        int  p, s, q, addr, m;
        real r;
        if (!en) return 128;
        p = int'((ph >> 16) & 32'd255);
        case (sel)
            0:       s = (p < 128) ? 127 : -127;
            1:       s = p - 128;
            2:       s = (p < 128) ? 2 * p - 127 : 2 * (255 - p) - 127;
            default: begin
                q    = p % 128;
                addr = (q < 64) ? q : 127 - q;
                r    = 127.0 * $sin((real'(addr) + 0.5) * Pi / 128.0);
                m    = int'($floor(r + 0.5));
                s    = (p < 128) ? m : -m;
            end
        endcase
        return int'($floor(real'(s * amp) / 256.0)) + 128;
    endfunction

    task automatic count_first_tick(input string tag);
        int n = 0;
        bit quiet = 1'b1;
        check({tag, "_rst_value"}, bus_if.value, 8'h80);
        check({tag, "_rst_valid"}, bus_if.value_valid, 1'b0);
        check({tag, "_rst_tick"}, bus_if.sample_tick, 1'b0);
        while (bus_if.sample_tick !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
            if (bus_if.value !== 8'h80 || bus_if.value_valid !== 1'b0) quiet = 1'b0;
        end
        check({tag, "_cycle"}, n, 255);
        check({tag, "_quiet"}, quiet, 1'b1);
    endtask

    // Called in a tick cycle: drives the captured inputs, scrambles them afterwards, checks timing.
    task automatic apply_and_check(input int unsigned fw, input int sel, input int amp,
                                   input bit en, input string tag);
        int exp;
        bus_if.freq_word = 24'(fw);
        bus_if.wave_sel  = wave_sel_e'(sel);
        bus_if.amplitude = 8'(amp);
        bus_if.enable    = en;
        phase_m = en ? ((phase_m + fw) & 32'hFF_FFFF) : 0;
        exp     = model_value(phase_m, sel, amp, en);
        @(negedge clk);
        bus_if.freq_word = 24'($urandom);
        bus_if.wave_sel  = wave_sel_e'($urandom_range(0, 3));
        bus_if.amplitude = 8'($urandom);
        bus_if.enable    = 1'($urandom);
        check({tag, "_valid_t1"}, bus_if.value_valid, 1'b0);
        @(negedge clk);
        check({tag, "_valid_t2"}, bus_if.value_valid, 1'b0);
        check({tag, "_old_t2"}, bus_if.value, last_exp);
        @(negedge clk);
        check({tag, "_valid_t3"}, bus_if.value_valid, 1'b1);
        check({tag, "_value"}, bus_if.value, exp);
        @(negedge clk);
        check({tag, "_valid_t4"}, bus_if.value_valid, 1'b0);
        last_exp = exp;
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        @(negedge clk);
        while (bus_if.sample_tick !== 1'b1 && n < SampleDiv + 4) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_tick"}, bus_if.sample_tick, 1'b1);
        check({tag, "_hold"}, bus_if.value, last_exp);
    endtask

    task automatic sample(input int unsigned fw, input int sel, input int amp, input bit en,
                          input string tag);
        wait_tick(tag);
        apply_and_check(fw, sel, amp, en, tag);
    endtask

    initial begin
        rst              = 1'b1;
        bus_if.enable    = 1'b1;
        bus_if.freq_word = 24'h040000;
        bus_if.wave_sel  = WAVE_SQUARE;
        bus_if.amplitude = 8'd255;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        count_first_tick("first_tick");

        // Square, p steps by 4 per sample starting at 4
        apply_and_check(24'h040000, 0, 255, 1'b1, "square");
        repeat (30) sample(24'h040000, 0, 255, 1'b1, "square");
        check("square_hi", bus_if.value, 8'd254);
        sample(24'h040000, 0, 255, 1'b1, "square");
        check("square_lo", bus_if.value, 8'd1);
        repeat (31) sample(24'h040000, 0, 255, 1'b1, "square");
        sample(24'h040000, 0, 255, 1'b1, "square");
        check("square_wrap", bus_if.value, 8'd254);

        // Enable low clears phase and silences; then saw endpoints and mute
        sample(24'h123456, 1, 255, 1'b0, "en_low");
        check("en_low_silence", bus_if.value, 8'd128);
        sample(24'h000000, 1, 255, 1'b1, "saw_p00");
        check("saw_p00_const", bus_if.value, 8'd0);
        sample(24'hFF0000, 1, 255, 1'b1, "saw_pff");
        check("saw_pff_const", bus_if.value, 8'd254);
        repeat (3) sample(24'hFF0000, 1, 255, 1'b1, "saw_down");
        sample(24'h040000, 1, 0, 1'b1, "saw_amp0");
        check("saw_amp0_const", bus_if.value, 8'd128);
        repeat (3) sample($urandom & 32'hFF_FFFF, 1, 0, 1'b1, "saw_amp0_rand");

        // Reverse step wraps 0x00 -> 0xFF
        sample(24'h000000, 1, 255, 1'b0, "wrap_clr");
        sample(24'h020000, 1, 255, 1'b1, "wrap_p02");
        sample(24'hFF0000, 1, 255, 1'b1, "wrap_p01");
        sample(24'hFF0000, 1, 255, 1'b1, "wrap_p00");
        check("wrap_p00_const", bus_if.value, 8'd0);
        sample(24'hFF0000, 1, 255, 1'b1, "wrap_pff");
        check("wrap_pff_const", bus_if.value, 8'd254);
        sample(24'hFF0000, 1, 255, 1'b1, "wrap_pfe");

        // Sine landmarks
        sample(24'h000000, 3, 255, 1'b0, "sine_clr");
        sample(24'h000000, 3, 255, 1'b1, "sine_p00");
        check("sine_p00_const", bus_if.value, 8'd129);
        sample(24'h400000, 3, 255, 1'b1, "sine_p40");
        check("sine_p40_const", bus_if.value, 8'd254);
        sample(24'h800000, 3, 255, 1'b1, "sine_pc0");
        check("sine_pc0_const", bus_if.value, 8'd1);

        repeat (32) sample(24'h080000, 2, 200, 1'b1, "tri");

        repeat (40) begin
            sample($urandom & 32'hFF_FFFF, $urandom_range(0, 3), $urandom_range(0, 255),
                   ($urandom_range(0, 9) != 0), "rand");
        end

        // Reset while a sample is in flight
        sample(24'h000000, 1, 255, 1'b0, "mid_rst_clr");
        sample(24'h100000, 1, 255, 1'b1, "mid_rst_pre");
        wait_tick("mid_rst");
        bus_if.freq_word = 24'h100000;
        bus_if.wave_sel  = WAVE_SAW;
        bus_if.amplitude = 8'd255;
        bus_if.enable    = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_value", bus_if.value, 8'h80);
        check("mid_rst_valid", bus_if.value_valid, 1'b0);
        check("mid_rst_tick", bus_if.sample_tick, 1'b0);
        @(negedge clk);
        check("mid_rst_discard_valid", bus_if.value_valid, 1'b0);
        check("mid_rst_discard_value", bus_if.value, 8'h80);
        rst      = 1'b0;
        phase_m  = 0;
        last_exp = 128;
        bus_if.freq_word = 24'h000000;
        count_first_tick("post_rst_tick");
        apply_and_check(24'h000000, 1, 255, 1'b1, "post_rst");
        check("post_rst_phase0", bus_if.value, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
